// File: rtl/raiz_seq_pkg.sv
// Shared definitions for the sequential integer square-root unit:
// FSM state encoding and the default radicand width.
package raiz_seq_pkg;

  localparam int DEF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/raiz_seq_paso.sv
// One restoring square-root iteration: shifts the next radicand bit pair into
// the partial remainder and tries to subtract (q << 2) | 1.
module paso_raiz #(
  parameter int N = 8
) (
  input  logic [N+1:0] rem,
  input  logic [N-1:0] q,
  input  logic [1:0]   pair,
  output logic [N+1:0] rem_next,
  output logic [N-1:0] q_next,
  output logic         sign
);

  logic        [N+1:0] shifted;
  logic        [N+1:0] trial;
  logic signed [N+1:0] diff;

  // The remainder stays below 2^N between steps, so the shift never loses bits
  // and the signed difference always fits in N+2 bits.
  always_comb begin
    shifted  = (rem << 2) | {{N{1'b0}}, pair};
    trial    = {q, 2'b01};
    diff     = signed'(shifted - trial);
    sign     = diff[N+1];
    rem_next = sign ? shifted : unsigned'(diff);
    q_next   = (q << 1) | {{(N-1){1'b0}}, ~sign};
  end

endmodule

// File: rtl/raiz_seq.sv
// Sequential floor square root: one result bit per cycle, N CALC cycles,
// results registered on entry to FIN together with a one-cycle done pulse.
module raiz_seq
  import raiz_seq_pkg::*;
#(
  parameter  int W = DEF_W,
  localparam int N = W / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] radicando,
  output logic [N-1:0] raiz,
  output logic [N:0]   residuo,
  output logic         exacta,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [W-1:0]  op;
  logic [N+1:0]  rem;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  logic [N+1:0]  rem_next;
  logic [N-1:0]  q_next;
  logic          step_sign_unused;

  // The bit pair consumed each cycle is always the top of the operand shifter.
  paso_raiz #(.N(N)) u_paso (
    .rem      (rem),
    .q        (q),
    .pair     (op[W-1:W-2]),
    .rem_next (rem_next),
    .q_next   (q_next),
    .sign     (step_sign_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= '0;
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      raiz    <= '0;
      residuo <= '0;
      exacta  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op    <= radicando;
            rem   <= '0;
            q     <= '0;
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          op  <= op << 2;
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          // Last pair consumed: publish the outcome of this very step.
          if (cnt == '0) begin
            raiz    <= q_next;
            residuo <= rem_next[N:0];
            exacta  <= (rem_next == '0);
            done    <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_seq.sv
// Bench for raiz_seq: W=16 and W=8 instances checked every cycle against a
// timing/arithmetic model, plus directed operations with literal expectations.
module tb_raiz_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start16, start8;
  logic [15:0] rad16;
  logic [7:0]  rad8;
  logic [7:0]  raiz16;
  logic [8:0]  res16;
  logic        ex16, busy16, done16;
  logic [3:0]  raiz8;
  logic [4:0]  res8;
  logic        ex8, busy8, done8;

  raiz_seq #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .radicando(rad16),
    .raiz(raiz16), .residuo(res16), .exacta(ex16), .busy(busy16), .done(done16)
  );

  raiz_seq #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .radicando(rad8),
    .raiz(raiz8), .residuo(res8), .exacta(ex8), .busy(busy8), .done(done8)
  );

  int checks = 0;
  int errors = 0;
  int nn[2] = '{8, 4};

  // Uniform views of both instances, index 0 = W16, 1 = W8.
  logic st[2];
  int   rad[2];
  int   d_r[2], d_s[2];
  logic d_x[2], d_b[2], d_d[2];
  always_comb begin
    st[0]  = start16;      st[1]  = start8;
    rad[0] = int'(rad16);  rad[1] = int'(rad8);
    d_r[0] = int'(raiz16); d_r[1] = int'(raiz8);
    d_s[0] = int'(res16);  d_s[1] = int'(res8);
    d_x[0] = ex16;         d_x[1] = ex8;
    d_b[0] = busy16;       d_b[1] = busy8;
    d_d[0] = done16;       d_d[1] = done8;
  end

  function automatic int isqrt(int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Model: ph counts edges left until idle again (N+1 after acceptance).
  int   ph[2]  = '{0, 0};
  int   opm[2] = '{0, 0};
  int   er[2]  = '{0, 0};
  int   es[2]  = '{0, 0};
  logic ex_[2] = '{1'b0, 1'b0};
  logic eb[2]  = '{1'b0, 1'b0};
  logic ed[2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] <= 0; opm[k] <= 0; er[k] <= 0; es[k] <= 0;
        ex_[k] <= 1'b0; eb[k] <= 1'b0; ed[k] <= 1'b0;
      end else if (ph[k] == 0) begin
        ed[k] <= 1'b0;
        eb[k] <= st[k];
        if (st[k]) begin
          ph[k]  <= nn[k] + 1;
          opm[k] <= rad[k];
        end
      end else begin
        ph[k] <= ph[k] - 1;
        ed[k] <= (ph[k] == 2);
        if (ph[k] == 2) begin
          er[k]  <= isqrt(opm[k]);
          es[k]  <= opm[k] - isqrt(opm[k]) * isqrt(opm[k]);
          ex_[k] <= (opm[k] == isqrt(opm[k]) * isqrt(opm[k]));
        end
        if (ph[k] == 1) eb[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("w%0d raiz", k), d_r[k], er[k]);
        chk($sformatf("w%0d residuo", k), d_s[k], es[k]);
        chk($sformatf("w%0d exacta", k), int'(d_x[k]), int'(ex_[k]));
        chk($sformatf("w%0d busy", k), int'(d_b[k]), int'(eb[k]));
        chk($sformatf("w%0d done", k), int'(d_d[k]), int'(ed[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic s, input int v);
    if (k == 0) begin start16 = s; rad16 = v[15:0]; end
    else begin start8 = s; rad8 = v[7:0]; end
  endtask

  // Starts from IDLE, returns in IDLE; exp_edges counts edges from acceptance
  // to the edge at which done is sampled high.
  task automatic run_op(input int k, input int v, input int exp_edges,
                        input int r, input int s, input int x);
    int n;
    n = 0;
    set_in(k, 1'b1, v);
    step();
    set_in(k, 1'b0, v);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (d_d[k]) begin n = i; break; end
    end
    if (n == 0) chk($sformatf("w%0d done timeout v=%0d", k, v), 0, 1);
    else begin
      chk($sformatf("w%0d latency v=%0d", k, v), n + 1, exp_edges);
      chk($sformatf("w%0d lit raiz v=%0d", k, v), d_r[k], r);
      chk($sformatf("w%0d lit residuo v=%0d", k, v), d_s[k], s);
      chk($sformatf("w%0d lit exacta v=%0d", k, v), int'(d_x[k]), x);
    end
    step();
  endtask

  initial begin
    int pulses, first, second, r;
    rst_n = 1'b0;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    step();
    step();
    cmp_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("w%0d reset raiz", k), d_r[k], 0);
      chk($sformatf("w%0d reset residuo", k), d_s[k], 0);
      chk($sformatf("w%0d reset exacta", k), int'(d_x[k]), 0);
      chk($sformatf("w%0d reset busy", k), int'(d_b[k]), 0);
      chk($sformatf("w%0d reset done", k), int'(d_d[k]), 0);
    end
    rst_n = 1'b1;
    step();

    run_op(0, 144, 9, 12, 0, 1);
    run_op(0, 0, 9, 0, 0, 1);
    run_op(0, 65535, 9, 255, 510, 0);

    // Starts at edges +3 and +7 while busy must be ignored.
    set_in(0, 1'b1, 2); step();
    set_in(0, 1'b0, 2); step(); step();
    set_in(0, 1'b1, 9999); step();
    set_in(0, 1'b0, 9999); step(); step(); step();
    set_in(0, 1'b1, 9999); step();
    set_in(0, 1'b0, 9999);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done16) pulses++;
    end
    chk("busy-start pulses", pulses, 1);
    chk("busy-start raiz", int'(raiz16), 1);
    chk("busy-start residuo", int'(res16), 1);

    // Reset at edge +4 aborts the operation.
    set_in(0, 1'b1, 1000); step();
    set_in(0, 1'b0, 1000); step(); step(); step();
    rst_n = 1'b0; step();
    chk("abort busy", int'(busy16), 0);
    chk("abort done", int'(done16), 0);
    chk("abort raiz", int'(raiz16), 0);
    chk("abort residuo", int'(res16), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done16) pulses++;
    end
    chk("abort no done", pulses, 0);
    run_op(0, 1000, 9, 31, 39, 0);

    run_op(1, 200, 5, 14, 4, 0);
    for (int v = 0; v < 256; v++) begin
      r = isqrt(v);
      run_op(1, v, 5, r, v - r * r, int'(v == r * r));
    end

    // start held high: back-to-back 49 then 50.
    set_in(0, 1'b1, 49); step();
    set_in(0, 1'b1, 50);
    first = 0; second = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done16) begin
        if (first == 0) begin
          first = i;
          chk("b2b first raiz", int'(raiz16), 7);
          chk("b2b first residuo", int'(res16), 0);
          chk("b2b first exacta", int'(ex16), 1);
        end else begin
          second = i;
          chk("b2b second raiz", int'(raiz16), 7);
          chk("b2b second residuo", int'(res16), 1);
          chk("b2b second exacta", int'(ex16), 0);
          set_in(0, 1'b0, 50);
          break;
        end
      end
    end
    chk("b2b spacing", second - first, 10);
    step();
    step();

    // Random traffic on both instances, occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      set_in(0, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 65535)));
      set_in(1, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)));
      step();
    end
    rst_n = 1'b1;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    for (int i = 0; i < 12; i++) step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
